// File: rtl/dkong_sound_mixer_if.sv
// Sound-board bus: i8035 DAC code, SFX trigger levels in; mixed PCM/PDM out.
interface dkong_sound_mixer_if;
    logic [7:0] dac_in;
    logic       dac_mute;
    logic       walk_in;
    logic       jump_in;
    logic       crash_in;
    logic [9:0] pcm_out;
    logic       pcm_valid;
    logic       pdm_out;

    modport master (
        output dac_in, dac_mute, walk_in, jump_in, crash_in,
        input  pcm_out, pcm_valid, pdm_out
    );
    modport slave (
        input  dac_in, dac_mute, walk_in, jump_in, crash_in,
        output pcm_out, pcm_valid, pdm_out
    );
endinterface

// File: rtl/dkong_sound_mixer.sv
// Donkey Kong sound mixer: DAC plus three decaying square-wave SFX voices,
// summed once per sample tick into offset-binary PCM and a 1st-order PDM stream.
module dkong_sound_voice #(
    parameter int HALF    = 40,
    parameter int ENV_DIV = 4
) (
    input  logic       masterclk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_trig,
    output logic [7:0] o_contrib
);
    localparam logic [7:0] HALF_M1 = 8'(HALF - 1);
    localparam logic [7:0] ENV_M1  = 8'(ENV_DIV - 1);

    logic [1:0] r_sync;
    logic       r_prev;
    logic       r_pend;
    logic       r_phase;
    logic [7:0] r_env;
    logic [7:0] r_tcnt;
    logic [7:0] r_dcnt;
    logic       w_edge;
    logic       w_load;
    logic [7:0] w_mag;

    assign w_edge = r_sync[1] & ~r_prev;
    // An edge arriving on the tick cycle is loaded directly, bypassing pending.
    assign w_load = i_tick & (r_pend | w_edge);
    assign w_mag  = {2'b00, r_env[7:2]};
    assign o_contrib = (r_env == 8'd0) ? 8'd0 : (r_phase ? w_mag : (~w_mag + 8'd1));

    always_ff @(posedge masterclk or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_prev  <= 1'b0;
            r_pend  <= 1'b0;
            r_phase <= 1'b0;
            r_env   <= 8'd0;
            r_tcnt  <= 8'd0;
            r_dcnt  <= 8'd0;
        end else begin
            r_sync <= {r_sync[0], i_trig};
            r_prev <= r_sync[1];
            if (w_load) begin
                r_pend  <= 1'b0;
                r_env   <= 8'd255;
                r_phase <= 1'b0;
                r_tcnt  <= 8'd0;
                r_dcnt  <= 8'd0;
            end else begin
                if (w_edge) r_pend <= 1'b1;
                if (i_tick && r_env != 8'd0) begin
                    if (r_tcnt == HALF_M1) begin
                        r_tcnt  <= 8'd0;
                        r_phase <= ~r_phase;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                    if (r_dcnt == ENV_M1) begin
                        r_dcnt <= 8'd0;
                        r_env  <= r_env - 8'd1;
                    end else begin
                        r_dcnt <= r_dcnt + 8'd1;
                    end
                end
            end
        end
    end
endmodule

module dkong_sound_mixer #(
    parameter int SAMPLE_DIV = 1024,
    parameter int WALK_HALF  = 40,
    parameter int JUMP_HALF  = 24,
    parameter int CRASH_HALF = 64,
    parameter int ENV_DIV    = 4
) (
    input  logic               masterclk,
    input  logic               rst,
    dkong_sound_mixer_if.slave bus
);
    localparam logic [15:0] TICK_AT = 16'(SAMPLE_DIV - 1);

    logic [15:0]     r_cnt;
    logic            w_tick;
    logic [2:0]      w_trig;
    logic [2:0][7:0] w_contrib;
    logic [8:0]      w_dac;
    logic [9:0]      w_sum;
    logic [9:0]      r_pcm;
    logic            r_valid;
    logic [10:0]     r_acc;

    assign w_tick = (r_cnt == TICK_AT);
    assign w_trig = {bus.crash_in, bus.jump_in, bus.walk_in};

    always_ff @(posedge masterclk or posedge rst) begin
        if (rst) r_cnt <= 16'd0;
        else     r_cnt <= w_tick ? 16'd0 : r_cnt + 16'd1;
    end

    for (genvar g = 0; g < 3; g++) begin : g_voice
        dkong_sound_voice #(
            .HALF   ((g == 0) ? WALK_HALF : ((g == 1) ? JUMP_HALF : CRASH_HALF)),
            .ENV_DIV(ENV_DIV)
        ) u_voice (
            .masterclk(masterclk),
            .rst      (rst),
            .i_tick   (w_tick),
            .i_trig   (w_trig[g]),
            .o_contrib(w_contrib[g])
        );
    end

    // dac_in - 128 in two's complement is just the code with its MSB inverted.
    assign w_dac = bus.dac_mute ? 9'd0 : {~bus.dac_in[7], bus.dac_in[7:0]} ^ 9'h080;
    assign w_sum = {w_dac[8], w_dac}
                 + {{2{w_contrib[0][7]}}, w_contrib[0]}
                 + {{2{w_contrib[1][7]}}, w_contrib[1]}
                 + {{2{w_contrib[2][7]}}, w_contrib[2]};

    // Adding 512 to a 10-bit signed sum is an MSB flip into offset binary.
    always_ff @(posedge masterclk or posedge rst) begin
        if (rst) begin
            r_pcm   <= 10'h200;
            r_valid <= 1'b0;
            r_acc   <= 11'd0;
        end else begin
            r_valid <= w_tick;
            if (w_tick) r_pcm <= {~w_sum[9], w_sum[8:0]};
            r_acc <= {1'b0, r_acc[9:0]} + {1'b0, r_pcm};
        end
    end

    assign bus.pcm_out   = r_pcm;
    assign bus.pcm_valid = r_valid;
    assign bus.pdm_out   = r_acc[10];
endmodule

// File: tb/tb_dkong_sound_mixer.sv
// Randomized + directed bench for dkong_sound_mixer against a closed-form voice model.
module tb_dkong_sound_mixer;
    localparam int SD  = 4;
    localparam int WH  = 2;
    localparam int JH  = 3;
    localparam int CH  = 5;
    localparam int ED  = 2;

    logic masterclk;
    logic rst;
    dkong_sound_mixer_if bus();

    dkong_sound_mixer #(
        .SAMPLE_DIV(SD), .WALK_HALF(WH), .JUMP_HALF(JH), .CRASH_HALF(CH), .ENV_DIV(ED)
    ) dut (
        .masterclk(masterclk),
        .rst      (rst),
        .bus      (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        masterclk = 1'b0;
        forever #5 masterclk = ~masterclk;
    end

    // Model: a voice is described only by the tick index at which it was loaded;
    // its envelope and phase at any later tick follow in closed form.
    int  m_c;
    int  m_load [3];
    bit  m_pend [3];
    bit  m_h0 [3], m_h1 [3], m_h2 [3];
    int  m_pcm;
    bit  m_valid;
    int  m_acc;
    int  m_k;
    int  m_s;
    bit  m_tick;
    bit  m_edge;
    bit  m_raw [3];

    function automatic int half_of(input int v);
        return (v == 0) ? WH : ((v == 1) ? JH : CH);
    endfunction

    function automatic int contrib(input int v, input int k);
        int u, env, mag;
        if (m_load[v] < 0) return 0;
        u   = k - m_load[v] - 1;
        env = 255 - u / ED;
        if (env <= 0) return 0;
        mag = env / 4;
        return ((u / half_of(v)) % 2 == 1) ? mag : -mag;
    endfunction

    always @(posedge masterclk or posedge rst) begin
        if (rst) begin
            m_c = 0; m_pcm = 512; m_valid = 0; m_acc = 0;
            for (int v = 0; v < 3; v++) begin
                m_load[v] = -1; m_pend[v] = 0;
                m_h0[v] = 0; m_h1[v] = 0; m_h2[v] = 0;
            end
        end else begin
            m_raw[0] = bus.walk_in; m_raw[1] = bus.jump_in; m_raw[2] = bus.crash_in;
            m_acc = (m_acc % 1024) + m_pcm;
            m_c++;
            m_tick  = (m_c % SD == 0);
            m_valid = m_tick;
            m_k = m_c / SD;
            if (m_tick) begin
                m_s = bus.dac_mute ? 0 : int'(bus.dac_in) - 128;
                for (int v = 0; v < 3; v++) m_s += contrib(v, m_k);
                m_pcm = 512 + m_s;
            end
            // A raw rising edge sampled at edge c is acted on at edge c+2.
            for (int v = 0; v < 3; v++) begin
                m_edge = m_h1[v] & ~m_h2[v];
                if (m_tick) begin
                    if (m_pend[v] || m_edge) begin
                        m_load[v] = m_k;
                        m_pend[v] = 0;
                    end
                end else if (m_edge) begin
                    m_pend[v] = 1;
                end
                m_h2[v] = m_h1[v]; m_h1[v] = m_h0[v]; m_h0[v] = m_raw[v];
            end
        end
    end

    always @(negedge masterclk) begin
        chk("pcm_out",   int'(bus.pcm_out),   m_pcm);
        chk("pcm_valid", int'(bus.pcm_valid), int'(m_valid));
        chk("pdm_out",   int'(bus.pdm_out),   int'(m_acc >= 1024));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge masterclk);
    endtask

    task automatic wait_valid(output int v);
        v = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge masterclk);
            if (bus.pcm_valid) begin
                v = int'(bus.pcm_out);
                break;
            end
        end
        if (v < 0) chk("valid_timeout", 0, 1);
    endtask

    task automatic pulse(input bit w, input bit j, input bit c);
        bus.walk_in = w; bus.jump_in = j; bus.crash_in = c;
        cyc(3);
        bus.walk_in = 0; bus.jump_in = 0; bus.crash_in = 0;
    endtask

    // Skip samples whose distance from `base` is at most `tol`; return the first other one.
    task automatic first_other(input int base, input int tol, output int v);
        int n;
        n = 0;
        do begin
            wait_valid(v);
            n++;
        end while ((v - base <= tol) && (base - v <= tol) && n < 20 && v >= 0);
        if (n >= 20) chk("audible_timeout", 0, 1);
    endtask

    int v, n, prev;
    int seq [5] = '{449, 449, 575, 575, 449};

    initial begin
        rst = 1;
        bus.dac_in = 8'h80; bus.dac_mute = 1;
        bus.walk_in = 0; bus.jump_in = 0; bus.crash_in = 0;
        cyc(3);
        chk("reset_pcm",   int'(bus.pcm_out),   512);
        chk("reset_valid", int'(bus.pcm_valid), 0);
        chk("reset_pdm",   int'(bus.pdm_out),   0);
        #2 rst = 0;

        // First tick lands SAMPLE_DIV cycles after release.
        n = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge masterclk);
            if (bus.pcm_valid) begin n = k; break; end
        end
        chk("first_tick", n, SD);
        chk("silence", int'(bus.pcm_out), 512);
        prev = bus.pdm_out;
        for (int k = 0; k < 8; k++) begin
            @(negedge masterclk);
            chk("pdm_alt", int'(bus.pdm_out), int'(!prev));
            prev = bus.pdm_out;
        end

        bus.dac_mute = 0; bus.dac_in = 8'hFF;
        wait_valid(v); chk("dac_ff", v, 639);
        n = 0;
        do begin @(negedge masterclk); n++; end while (!bus.pcm_valid && n < 64);
        chk("tick_spacing", n, SD);
        bus.dac_in = 8'h00;
        wait_valid(v); chk("dac_00", v, 384);

        bus.dac_mute = 1; bus.dac_in = 8'h80;
        pulse(1, 0, 0);
        first_other(512, 0, v);
        chk("walk_seq0", v, seq[0]);
        for (int k = 1; k < 5; k++) begin
            wait_valid(v);
            chk("walk_seq", v, seq[k]);
        end

        cyc(SD * 530);
        wait_valid(v); chk("decayed", v, 512);

        // Retrigger once the envelope has fallen to about 100.
        pulse(1, 0, 0);
        cyc(SD * 312);
        pulse(1, 0, 0);
        first_other(512, 40, v);
        chk("retrigger", v, 449);

        // Reset mid-note with the trigger held through release.
        cyc(SD * 3);
        bus.walk_in = 1;
        #2 rst = 1;
        #1;
        chk("midnote_rst_pcm",   int'(bus.pcm_out),   512);
        chk("midnote_rst_valid", int'(bus.pcm_valid), 0);
        cyc(3);
        #2 rst = 0;
        first_other(512, 0, v);
        chk("held_trigger", v, 449);
        bus.walk_in = 0;

        #2 rst = 1;
        cyc(2);
        #2 rst = 0;
        bus.dac_mute = 0; bus.dac_in = 8'hFF;
        pulse(1, 1, 1);
        first_other(639, 0, v);
        chk("all_three", v, 450);

        for (int k = 0; k < 1600; k++) begin
            @(negedge masterclk);
            if ($urandom_range(3) == 0) bus.dac_in = 8'($urandom);
            bus.dac_mute = ($urandom_range(7) == 0);
            if ($urandom_range(29) == 0) bus.walk_in  = ~bus.walk_in;
            if ($urandom_range(29) == 0) bus.jump_in  = ~bus.jump_in;
            if ($urandom_range(29) == 0) bus.crash_in = ~bus.crash_in;
        end
        cyc(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
